// File: rtl/button_panel_ctrl.sv
// rtl/button_panel_ctrl.sv - illuminated button panel: lit mask, lowest-index select, sparkle blink.
// Optional idle-round timeout enabled by defining BUTTON_PANEL_TIMEOUT_EN.
module button_panel_ctrl #(
  parameter int N_BTN       = 8,
  parameter int BLINK_CNT   = 12500000,
  parameter int TIMEOUT_CNT = 500000000,
  localparam int IDX_W      = $clog2(N_BTN)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [N_BTN-1:0] i_mask,
  input  logic [N_BTN-1:0] i_select,
  output logic [N_BTN-1:0] o_exist,
  output logic             o_sparkle,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_index,
  input  logic             i_ready,
  output logic             o_timeout
);

  localparam int BL_W = $clog2(BLINK_CNT + 1);
  localparam logic [BL_W-1:0]  BL_LAST = BL_W'(BLINK_CNT - 1);
  localparam logic [N_BTN-1:0] ONE     = N_BTN'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_REPORT} state_t;

  state_t           state;
  logic [BL_W-1:0]  blink_cnt;
  logic [N_BTN-1:0] cand;
  logic [N_BTN-1:0] cand_lsb;
  logic [IDX_W-1:0] winner;

  if (N_BTN < 2 || N_BTN > 32 || BLINK_CNT < 1 || TIMEOUT_CNT < 1) begin : g_bad_param
    $error("button_panel_ctrl: parameter out of range");
  end

  // cand_lsb isolates the lowest requesting lit button by two's-complement.
  always_comb begin
    cand     = i_select & o_exist;
    cand_lsb = cand & (~cand + ONE);
    winner   = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (cand[i]) winner = IDX_W'(i);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_cnt <= '0;
      o_sparkle <= 1'b0;
    end else if (i_load) begin
      blink_cnt <= '0;
      o_sparkle <= 1'b1;
    end else if (blink_cnt == BL_LAST) begin
      blink_cnt <= '0;
      o_sparkle <= ~o_sparkle;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

`ifdef BUTTON_PANEL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CNT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CNT - 1);
  logic [TO_W-1:0] idle_cnt;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      o_exist <= '0;
      o_valid <= 1'b0;
      o_index <= '0;
`ifdef BUTTON_PANEL_TIMEOUT_EN
      idle_cnt  <= '0;
      o_timeout <= 1'b0;
`endif
    end else begin
`ifdef BUTTON_PANEL_TIMEOUT_EN
      o_timeout <= 1'b0;
`endif
      // A load overrides any select, transfer or timeout in the same cycle.
      if (i_load) begin
        o_exist <= i_mask;
        o_valid <= 1'b0;
        state   <= (i_mask != '0) ? S_ARMED : S_IDLE;
`ifdef BUTTON_PANEL_TIMEOUT_EN
        idle_cnt <= '0;
`endif
      end else begin
        case (state)
          S_ARMED: begin
            if (cand != '0) begin
              o_exist <= o_exist & ~cand_lsb;
              o_index <= winner;
              o_valid <= 1'b1;
              state   <= S_REPORT;
`ifdef BUTTON_PANEL_TIMEOUT_EN
              idle_cnt <= '0;
            end else if (idle_cnt == TO_LAST) begin
              o_timeout <= 1'b1;
              o_exist   <= '0;
              state     <= S_IDLE;
              idle_cnt  <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
`endif
            end
          end
          S_REPORT: begin
            if (i_ready) begin
              o_valid <= 1'b0;
              state   <= (o_exist != '0) ? S_ARMED : S_IDLE;
`ifdef BUTTON_PANEL_TIMEOUT_EN
              idle_cnt <= '0;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
